// File: rtl/vlogic_pred_pipe.sv
// Predicated vector bitwise-logic unit feeding a collapsing valid/ready pipeline.
// Inactive elements keep the old destination value; byte enables travel with each beat.
module vlogic_pred_pipe #(
    parameter int REQ_DATA_WIDTH   = 64,
    parameter int REQ_ADDR_WIDTH   = 32,
    parameter int OPSEL_WIDTH      = 3,
    parameter int NUM_STAGES       = 6,
    parameter int MASK_ENABLE      = 1,
    parameter int VEC_MOVE_ENABLE  = 1,
    parameter int WHOLE_REG_ENABLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REQ_ADDR_WIDTH-1:0]   in_addr,
    input  logic [REQ_DATA_WIDTH-1:0]   in_vec0,
    input  logic [REQ_DATA_WIDTH-1:0]   in_vec1,
    input  logic [REQ_DATA_WIDTH-1:0]   in_old,
    input  logic [OPSEL_WIDTH-1:0]      in_opSel,
    input  logic [1:0]                  in_sew,
    input  logic                        in_vm,
    input  logic [REQ_DATA_WIDTH/8-1:0] in_vmask,
    input  logic                        in_sca,
    input  logic                        in_w_reg,
    input  logic                        in_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [REQ_DATA_WIDTH-1:0]   out_vec,
    output logic [REQ_DATA_WIDTH/8-1:0] out_be,
    output logic [REQ_ADDR_WIDTH-1:0]   out_addr,
    output logic                        out_sca,
    output logic                        out_w_reg,
    output logic                        out_mask
);

    localparam int NB   = REQ_DATA_WIDTH / 8;
    localparam int LAST = NUM_STAGES - 1;

    function automatic logic [REQ_DATA_WIDTH-1:0] vlogic_op(
        input logic [2:0]                op,
        input logic [REQ_DATA_WIDTH-1:0] a,
        input logic [REQ_DATA_WIDTH-1:0] b
    );
        logic [REQ_DATA_WIDTH-1:0] r;
        if (MASK_ENABLE != 0) begin
            case (op)
                3'b000:  r = a & ~b;
                3'b001:  r = a & b;
                3'b010:  r = a | b;
                3'b011:  r = a ^ b;
                3'b100:  r = a | ~b;
                3'b101:  r = ~(a & b);
                3'b110:  r = ~(a | b);
                3'b111:  r = ~(a ^ b);
                default: r = '0;
            endcase
        end else begin
            case (op[1:0])
                2'b01:   r = a & b;
                2'b10:   r = a | b;
                2'b11:   r = a ^ b;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Byte j belongs to element j >> sew; mask bits beyond the element count are never indexed.
    function automatic logic [NB-1:0] elem_be(
        input logic [1:0]    sew,
        input logic          vm,
        input logic [NB-1:0] vmask
    );
        logic [NB-1:0] be;
        be = '0;
        for (int j = 0; j < NB; j++) begin
            be[j] = vm | vmask[j >> sew];
        end
        return be;
    endfunction

    logic [REQ_DATA_WIDTH-1:0] res_s;
    logic [REQ_DATA_WIDTH-1:0] merged_s;
    logic [NB-1:0]             be_s;
    logic [2:0]                flags_s;
    logic                      vm_s;

    logic [REQ_DATA_WIDTH-1:0] vec_r  [NUM_STAGES];
    logic [NB-1:0]             be_r   [NUM_STAGES];
    logic [REQ_ADDR_WIDTH-1:0] addr_r [NUM_STAGES];
    logic [2:0]                flag_r [NUM_STAGES];
    logic [NUM_STAGES-1:0]     vld_r;
    logic [NUM_STAGES-1:0]     adv_s;
    logic                      full_s;

    // Input-side compute, predication merge and flag gating.
    always_comb begin
        vm_s     = (MASK_ENABLE != 0) ? in_vm : 1'b1;
        res_s    = vlogic_op(in_opSel[2:0], in_vec0, in_vec1);
        be_s     = elem_be(in_sew, vm_s, in_vmask);
        merged_s = in_old;
        for (int j = 0; j < NB; j++) begin
            merged_s[j*8 +: 8] = be_s[j] ? res_s[j*8 +: 8] : in_old[j*8 +: 8];
        end
        flags_s[2] = (VEC_MOVE_ENABLE != 0) ? in_sca : 1'b0;
        flags_s[1] = ((VEC_MOVE_ENABLE != 0) && (WHOLE_REG_ENABLE != 0)) ? in_w_reg : 1'b0;
        flags_s[0] = (MASK_ENABLE != 0) ? in_mask : 1'b0;
    end

    // A stage may advance unless it and every stage downstream are full while the output stalls.
    always_comb begin
        full_s = 1'b1;
        adv_s  = '0;
        for (int s = LAST; s >= 0; s--) begin
            full_s   = full_s & vld_r[s];
            adv_s[s] = !full_s || out_ready;
        end
    end

    // Pipeline registers; invalid predecessors propagate as bubbles that get squeezed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                vec_r[s]  <= '0;
                be_r[s]   <= '0;
                addr_r[s] <= '0;
                flag_r[s] <= 3'b000;
            end
        end else begin
            if (adv_s[0]) begin
                vld_r[0]  <= in_valid;
                vec_r[0]  <= merged_s;
                be_r[0]   <= be_s;
                addr_r[0] <= in_addr;
                flag_r[0] <= flags_s;
            end
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (adv_s[s]) begin
                    vld_r[s]  <= vld_r[s-1];
                    vec_r[s]  <= vec_r[s-1];
                    be_r[s]   <= be_r[s-1];
                    addr_r[s] <= addr_r[s-1];
                    flag_r[s] <= flag_r[s-1];
                end
            end
        end
    end

    assign in_ready  = rst_n & adv_s[0];
    assign out_valid = vld_r[LAST];
    assign out_vec   = out_valid ? vec_r[LAST]  : '0;
    assign out_be    = out_valid ? be_r[LAST]   : '0;
    assign out_addr  = out_valid ? addr_r[LAST] : '0;
    assign out_sca   = out_valid & flag_r[LAST][2];
    assign out_w_reg = out_valid & flag_r[LAST][1];
    assign out_mask  = out_valid & flag_r[LAST][0];

endmodule

// File: tb/tb_vlogic_pred_pipe.sv
// Bench for vlogic_pred_pipe: a scoreboard model checked every cycle plus directed literal cases.
module tb_vlogic_pred_pipe;

    localparam int W  = 64;
    localparam int NB = 8;
    localparam int AW = 32;
    localparam int NS = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, out_ready;
    logic [AW-1:0] in_addr;
    logic [W-1:0]  in_vec0, in_vec1, in_old;
    logic [2:0]    in_opSel;
    logic [1:0]    in_sew;
    logic          in_vm, in_sca, in_w_reg, in_mask;
    logic [NB-1:0] in_vmask;

    logic          in_ready, out_valid, out_sca, out_w_reg, out_mask;
    logic [W-1:0]  out_vec;
    logic [NB-1:0] out_be;
    logic [AW-1:0] out_addr;

    logic          in_ready0, out_valid0, out_sca0, out_w_reg0, out_mask0;
    logic [W-1:0]  out_vec0;
    logic [NB-1:0] out_be0;
    logic [AW-1:0] out_addr0;

    always #5 clk = ~clk;

    vlogic_pred_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1), .in_old(in_old),
        .in_opSel(in_opSel), .in_sew(in_sew), .in_vm(in_vm), .in_vmask(in_vmask),
        .in_sca(in_sca), .in_w_reg(in_w_reg), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_be(out_be),
        .out_addr(out_addr), .out_sca(out_sca), .out_w_reg(out_w_reg), .out_mask(out_mask)
    );

    vlogic_pred_pipe #(.MASK_ENABLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1), .in_old(in_old),
        .in_opSel(in_opSel), .in_sew(in_sew), .in_vm(in_vm), .in_vmask(in_vmask),
        .in_sca(in_sca), .in_w_reg(in_w_reg), .in_mask(in_mask),
        .out_valid(out_valid0), .out_ready(out_ready), .out_vec(out_vec0), .out_be(out_be0),
        .out_addr(out_addr0), .out_sca(out_sca0), .out_w_reg(out_w_reg0), .out_mask(out_mask0)
    );

    typedef struct {
        logic [W-1:0]  vec;
        logic [NB-1:0] be;
        logic [AW-1:0] addr;
        logic [2:0]    fl;
        int            t;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mfull(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & ~b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return a | ~b;
            3'd5:    return ~(a & b);
            3'd6:    return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    // Element-by-element reference: SEW-wide elements, active ones take the op result.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] old, input logic [1:0] sew, input logic vm,
                         input logic [NB-1:0] vmask, output logic [W-1:0] vec, output logic [NB-1:0] be);
        logic [W-1:0] full;
        int esz, n;
        logic act;
        full = mfull(op, a, b);
        esz  = 8 << sew;
        n    = W / esz;
        vec  = '0;
        be   = '0;
        for (int e = 0; e < n; e++) begin
            act = vm || vmask[e];
            for (int k = 0; k < esz; k++) vec[e*esz + k] = act ? full[e*esz + k] : old[e*esz + k];
            for (int bb = 0; bb < esz/8; bb++) be[e*esz/8 + bb] = act;
        end
    endtask

    // Per-cycle compare against the scoreboard, then retire/accept bookkeeping.
    always @(negedge clk) begin
        logic exp_valid;
        logic [W-1:0]  mv;
        logic [NB-1:0] mb;
        cyc++;
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'((q.size() < NS) || out_ready));
            exp_valid = (q.size() > 0) && (cyc >= q[0].t + NS) && (cyc > last_pop);
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            if (out_valid && exp_valid) begin
                chk("out_vec", out_vec, q[0].vec);
                chk("out_be", 64'(out_be), 64'(q[0].be));
                chk("out_addr", 64'(out_addr), 64'(q[0].addr));
                chk("out_flags", 64'({out_sca, out_w_reg, out_mask}), 64'(q[0].fl));
            end else if (!out_valid) begin
                chk("idle_gated", 64'(out_vec | 64'(out_be) | 64'(out_addr) |
                                      64'({out_sca, out_w_reg, out_mask})), 64'd0);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                last_pop = cyc;
            end
            if (in_valid && in_ready) begin
                model(in_opSel, in_vec0, in_vec1, in_old, in_sew, in_vm, in_vmask, mv, mb);
                q.push_back('{vec: mv, be: mb, addr: in_addr, fl: {in_sca, in_w_reg, in_mask}, t: cyc});
            end
        end
    end

    task automatic drive_beat(input logic [2:0] op, input logic [1:0] sew, input logic vm,
                              input logic [NB-1:0] vmask, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] old, input logic [AW-1:0] addr, input logic [2:0] fl);
        in_opSel = op; in_sew = sew; in_vm = vm; in_vmask = vmask;
        in_vec0 = a; in_vec1 = b; in_old = old; in_addr = addr;
        {in_sca, in_w_reg, in_mask} = fl;
        in_valid = 1'b1;
    endtask

    task automatic push_wait(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
    endtask

    task automatic wait_out(input bit sel0, output int k, output bit got,
                            output logic [W-1:0] v, output logic [NB-1:0] b, output logic m);
        got = 1'b0; k = 0; v = '0; b = '0; m = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (sel0 ? out_valid0 : out_valid) begin
                k = c; got = 1'b1;
                v = sel0 ? out_vec0 : out_vec;
                b = sel0 ? out_be0 : out_be;
                m = sel0 ? out_mask0 : out_mask;
                break;
            end
        end
        if (!got) begin
            failures++;
            $display("FAIL wait_out: got no output expected one within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, got, m;
        int k, acc, rdy_cnt, vld_cnt;
        logic [W-1:0] v;
        logic [NB-1:0] b;

        in_valid = 1'b0; out_ready = 1'b1;
        drive_beat(3'd0, 2'd0, 1'b0, '0, '0, '0, '0, '0, 3'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 64'(in_ready), 64'd1);

        // Unpredicated XOR, latency and single-cycle valid.
        drive_beat(3'b011, 2'b00, 1'b1, 8'h00, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, '0, 32'h100, 3'b000);
        push_wait(5, ok); in_valid = 1'b0;
        chk("xor_accept", 64'(ok), 64'd1);
        wait_out(1'b0, k, got, v, b, m);
        chk("xor_latency", 64'(k), 64'd6);
        chk("xor_vec", v, 64'hF00FF00FF00FF00F);
        chk("xor_be", 64'(b), 64'hFF);
        @(negedge clk);
        chk("xor_one_cycle", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        drive_beat(3'b001, 2'b10, 1'b0, 8'h01, '1, 64'h123456789ABCDEF0, 64'hAAAAAAAAAAAAAAAA, 32'h104, 3'b000);
        push_wait(5, ok); in_valid = 1'b0;
        wait_out(1'b0, k, got, v, b, m);
        chk("pred32_vec", v, 64'hAAAAAAAA9ABCDEF0);
        chk("pred32_be", 64'(b), 64'h0F);

        drive_beat(3'b001, 2'b00, 1'b0, 8'hA5, '1, 64'h123456789ABCDEF0, 64'hAAAAAAAAAAAAAAAA, 32'h108, 3'b000);
        push_wait(5, ok); in_valid = 1'b0;
        wait_out(1'b0, k, got, v, b, m);
        chk("pred8_vec", v, 64'h12AA56AAAABCAAF0);
        chk("pred8_be", 64'(b), 64'hA5);

        // SEW=64 has one element, so mask bit 1 must be ignored.
        drive_beat(3'b010, 2'b11, 1'b0, 8'h02, '1, '1, 64'h0123456789ABCDEF, 32'h10C, 3'b111);
        push_wait(5, ok); in_valid = 1'b0;
        wait_out(1'b0, k, got, v, b, m);
        chk("pred64_vec", v, 64'h0123456789ABCDEF);
        chk("pred64_be", 64'(b), 64'h00);

        for (int op = 0; op < 8; op++) begin
            drive_beat(3'(op), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                       {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                       32'h200 + 32'(op), 3'($urandom));
            push_wait(5, ok);
            chk("sweep_accept", 64'(ok), 64'd1);
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk); #1;

        // Random valid/ready traffic to exercise stalls and bubble collapse.
        for (int c = 0; c < 60; c++) begin
            drive_beat(3'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
                       {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                       32'h300 + 32'(c), 3'($urandom));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;

        // Backpressure: capacity of exactly NS beats.
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive_beat(3'b011, 2'b00, 1'b1, '0, 64'(i), 64'hFFFF, '0, 32'h400 + 32'(i), 3'b000);
            push_wait(8, ok);
            if (!ok) break;
            acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd6);
        @(negedge clk);
        chk("bp_full_not_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = acc; i < 8; i++) begin
            drive_beat(3'b011, 2'b00, 1'b1, '0, 64'(i), 64'hFFFF, '0, 32'h400 + 32'(i), 3'b000);
            push_wait(8, ok);
            chk("bp_rest_accept", 64'(ok), 64'd1);
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk); #1;

        // Full-pipe streaming.
        out_ready = 1'b0;
        for (int i = 0; i < NS; i++) begin
            drive_beat(3'b010, 2'b01, 1'b1, '0, 64'(i), 64'h100, '0, 32'h500 + 32'(i), 3'b010);
            push_wait(5, ok);
        end
        out_ready = 1'b1; rdy_cnt = 0; vld_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            drive_beat(3'b010, 2'b01, 1'b1, '0, 64'(c + 10), 64'h100, '0, 32'h600 + 32'(c), 3'b100);
            @(negedge clk);
            if (in_ready) rdy_cnt++;
            if (out_valid) vld_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stream_ready_cycles", 64'(rdy_cnt), 64'd20);
        chk("stream_valid_cycles", 64'(vld_cnt), 64'd20);
        repeat (10) @(posedge clk); #1;

        // Asynchronous reset with beats in flight and one presented at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_beat(3'b001, 2'b00, 1'b1, '0, '1, 64'(i + 1), '0, 32'h700 + 32'(i), 3'b001);
            push_wait(5, ok);
        end
        in_valid = 1'b0;
        wait_out(1'b0, k, got, v, b, m);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_vec", out_vec, 64'd0);
        chk("async_out_be", 64'(out_be), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1; vld_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) vld_cnt++;
        end
        chk("post_reset_idle", 64'(vld_cnt), 64'd0);
        @(posedge clk); #1;

        // MASK_ENABLE=0 build.
        drive_beat(3'b000, 2'b00, 1'b1, '0, 64'hFFFF0000FFFF0000, 64'h00FF00FF00FF00FF, '0, 32'h800, 3'b001);
        push_wait(5, ok);
        drive_beat(3'b010, 2'b00, 1'b0, 8'h00, 64'hF0F0000011110000, 64'h0000F0F000002222, 64'h5555555555555555, 32'h804, 3'b001);
        push_wait(5, ok);
        in_valid = 1'b0;
        wait_out(1'b1, k, got, v, b, m);
        chk("nomask_op0_vec", v, 64'd0);
        wait_out(1'b1, k, got, v, b, m);
        chk("nomask_or_vec", v, 64'hF0F0F0F011112222);
        chk("nomask_or_be", 64'(b), 64'hFF);
        chk("nomask_mask_flag", 64'(m), 64'd0);

        repeat (12) @(posedge clk); #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vlogic_pred_pipe.md
Name: vlogic_pred_pipe

Overview:
Parametrised successor to the vector AND/OR/XOR unit in the vALU. It computes the eight bitwise vector ops, with per-element predication by SEW and merge of the old destination value. The result passes through a NUM_STAGES-deep pipeline that supports valid/ready backpressure and bubble collapsing. It sits between the vALU issue logic and the register-file writeback arbiter, and also drives byte enables for writeback.

Parameters:
REQ_DATA_WIDTH, 64, datapath width in bits; multiple of 64.
REQ_ADDR_WIDTH, 32, destination address width.
OPSEL_WIDTH, 3, op select width.
NUM_STAGES, 6, pipeline depth; must be >= 1.
MASK_ENABLE, 1, 1 = all 8 ops plus predication; 0 = only AND/OR/XOR, with predication disabled.
VEC_MOVE_ENABLE, 1, 1 = carry sca through the pipeline.
WHOLE_REG_ENABLE, 1, 1 = carry w_reg through the pipeline; only effective when VEC_MOVE_ENABLE=1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
in_addr  in  REQ_ADDR_WIDTH  destination address.
in_vec0  in  REQ_DATA_WIDTH  operand 0.
in_vec1  in  REQ_DATA_WIDTH  operand 1.
in_old  in  REQ_DATA_WIDTH  old destination value, merged into inactive elements.
in_opSel  in  OPSEL_WIDTH  op select.
in_sew  in  2  element width: 00=8, 01=16, 10=32, 11=64 bits.
in_vm  in  1  1 = unpredicated (all elements active).
in_vmask  in  REQ_DATA_WIDTH/8  per-element mask; bit i controls element i.
in_sca  in  1  scalar-move flag, passed through.
in_w_reg  in  1  whole-register flag, passed through.
in_mask  in  1  mask-logical flag, passed through.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_vec  out  REQ_DATA_WIDTH  result.
out_be  out  REQ_DATA_WIDTH/8  byte enables; 1 = byte belongs to an active element.
out_addr  out  REQ_ADDR_WIDTH  address.
out_sca  out  1  sca flag.
out_w_reg  out  1  w_reg flag.
out_mask  out  1  mask flag.

Behaviour:
- Ops, MASK_ENABLE=1 (a=in_vec0, b=in_vec1):
  - 000 = a&~b, 001 = a&b, 010 = a|b, 011 = a^b
  - 100 = a|~b, 101 = ~(a&b), 110 = ~(a|b), 111 = ~(a^b)
- Ops, MASK_ENABLE=0: in_opSel[1:0] 01/10/11 = and/or/xor; 00 yields 0. in_vm is treated as 1 and out_mask is forced to 0.
- Predication:
  - N = REQ_DATA_WIDTH/SEW elements per beat.
  - Element i is active iff in_vm || in_vmask[i]; in_vmask bits >= N are ignored.
  - Active element bytes take the op result; inactive element bytes take in_old.
  - out_be byte j = active(element j*8/SEW).
- Compute and merge happen combinationally at the input and are registered into stage 0 on accept.
- Pipeline:
  - Stages 0..NUM_STAGES-1, each holding valid, data, be, addr and flags.
  - adv[last] = !v[last] || out_ready; adv[s] = !v[s] || adv[s+1].
  - A stage loads from its predecessor when adv[s]; it loads invalid if the predecessor is empty or stalled.
  - in_ready = adv[0]. The ready chain is combinational from out_ready.
  - Bubbles collapse, so a stalled output lets earlier stages fill.
  - Capacity is exactly NUM_STAGES beats.
- Latency is NUM_STAGES cycles from accept to out_valid when not stalled; throughput is 1 beat/cycle.
- Output holds stable while out_valid && !out_ready.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- A full pipeline with out_ready=1 and in_valid=1 accepts a new beat and emits one in the same cycle.
- Payload fields may be don't-care in invalid stages. Outputs are gated to 0 when out_valid=0.
- Flags gated by disabled parameters read 0.
- Reset:
  - rst_n low immediately clears all valids; all outputs go to 0 and in_ready=0 while in reset.
  - In-flight beats are discarded. There is no output until new accepts occur after rst_n rises.

Test Plan:
- Unpredicated XOR: W=64, sew=00, vm=1, op=011, vec0=0xFF00FF00FF00FF00, vec1=0x0F0F0F0F0F0F0F0F -> 6 cycles later out_vec=0xF00FF00FF00FF00F, out_be=0xFF, out_valid=1 for 1 cycle.
- Predication: sew=10, vm=0, vmask=0x01, op=001, vec0=all ones, vec1=0x123456789ABCDEF0, old=0xAAAAAAAAAAAAAAAA -> out_vec=0xAAAAAAAA9ABCDEF0, out_be=0x0F. Repeat with sew=00, vmask=0xA5 -> out_be=0xA5.
- Backpressure: hold out_ready=0 and offer 8 beats -> exactly 6 accepted, then in_ready=0. Raise out_ready -> 6 beats emerge in order on consecutive cycles, then the remaining 2 follow.
- Full-pipe streaming: pipeline full, out_ready=1, in_valid=1 continuously for 20 cycles -> in_ready=1 every cycle, 20 results in order, no bubbles.
- Async reset: rst_n pulsed low mid-cycle with 3 beats in flight -> out_valid=0 and outputs 0 without a clock edge. After release, no output appears for 6 idle cycles.
- MASK_ENABLE=0 build: op=000 -> out_vec=0; op=010 with vm=0, vmask=0 -> full OR result, out_be all ones, out_mask=0.
